conv_window_gen: RTL and testbench



---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_line_buffer.sv | 30 +++
 rtl/conv_window_gen.sv | 170 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the conv window generator slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

    localparam int SIZE_DEF      = 3;
    localparam int WIDTH_BIT_DEF = 8;

    typedef logic signed [WIDTH_BIT_DEF-1:0] pixel_t;

    // FILL: fewer than SIZE-1 full lines buffered; RUN: windows may be emitted.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : conv_pkg

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage; read-before-write at a single shared address.
// Latency: read is combinational from the current contents; write lands on the clock edge.
// Backpressure: none; the caller gates writes with we.
//
// Ports: clock; we (write enable); addr (column); wdata (pixel written at addr);
//        rdata (value stored at addr before this cycle's write).
// Contents are not reset: the owner never trusts them until a full line is written.
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule : conv_line_buffer

// File: rtl/conv_window_gen.sv
// Streams raster pixels in and emits a registered SIZE x SIZE valid-mode sliding window.
// Latency: 1 cycle from pixel accept to window; one window per accepted pixel once populated.
// Backpressure: single-entry output, no skid; pix_ready = !win_valid || win_ready.
//
// Ports: clock/reset (sync, active-high); pix_in/pix_valid/pix_ready/pix_last input stream;
//        win_out/win_valid/win_ready window stream, win_out[0][0] oldest line leftmost column,
//        win_out[SIZE-1][SIZE-1] newest pixel; frame_done pulses with the frame's last window.
// Optional: CONV_WINDOW_GEN_LAST_CHECK_EN adds sticky frame_err for misplaced/missing pix_last.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int SIZE      = SIZE_DEF,
    parameter int WIDTH_BIT = WIDTH_BIT_DEF,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic signed [WIDTH_BIT-1:0]                   pix_in,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    input  logic                                          pix_last,
    output logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_out,
    output logic                                          win_valid,
    input  logic                                          win_ready,
    output logic                                          frame_done
`ifdef CONV_WINDOW_GEN_LAST_CHECK_EN
    ,
    output logic                                          frame_err
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FULL = CW'(SIZE - 1);
    localparam logic [RW-1:0] ROW_FULL = RW'(SIZE - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    state_t        state_q, state_d;
    logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_q, win_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          at_final;
    logic [WIDTH_BIT-1:0] lb_rd [SIZE-1];

    assign pix_ready  = !win_valid_q || win_ready;
    assign accept     = pix_valid && pix_ready;
    assign at_final   = (col_q == COL_LAST) && (row_q == ROW_LAST);

    assign win_out    = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

    // Line buffers form a cascade: buffer 0 holds the oldest line, buffer SIZE-2
    // the line just above the current one. Each accept moves the column down one level.
    for (genvar g = 0; g < SIZE - 1; g++) begin : g_lb
        logic [WIDTH_BIT-1:0] lb_wr;
        if (g == SIZE - 2) begin : g_newest
            assign lb_wr = pix_in;
        end else begin : g_older
            assign lb_wr = lb_rd[g+1];
        end
        conv_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (WIDTH_BIT),
            .AW    (CW)
        ) u_lb (
            .clock (clock),
            .we    (accept),
            .addr  (col_q),
            .wdata (lb_wr),
            .rdata (lb_rd[g])
        );
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        win_d        = win_q;
        frame_done_d = 1'b0;

        if (accept) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            for (int i = 0; i < SIZE - 1; i++) begin
                win_d[i][SIZE-1] = lb_rd[i];
            end
            win_d[SIZE-1][SIZE-1] = pix_in;

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                FILL:    if (row_q == ROW_FULL && col_q == '0) state_d = RUN;
                RUN:     if (at_final) state_d = FILL;
                default: state_d = FILL;
            endcase

            frame_done_d = at_final;
        end

        // A fresh window wins over a downstream pop in the same cycle. Columns
        // below SIZE-1 would straddle the previous line, so they never qualify.
        if (accept && state_q == RUN && col_q >= COL_FULL) begin
            win_valid_d = 1'b1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= FILL;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef CONV_WINDOW_GEN_LAST_CHECK_EN
    logic frame_err_q, frame_err_d;

    // pix_last must be set exactly on the final raster position.
    always_comb begin
        frame_err_d = frame_err_q;
        if (accept && (pix_last != at_final)) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic unused_pix_last;
    assign unused_pix_last = pix_last;
`endif

endmodule : conv_window_gen

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen with SIZE=3, IMG_W=5, IMG_H=4, pixel = base + row*5 + col.
module tb_conv_window_gen;

    localparam int SIZE = 3;
    localparam int WB   = 8;
    localparam int IW   = 5;
    localparam int IH   = 4;
    localparam int NPIX = IW * IH;

    typedef logic [SIZE-1:0][SIZE-1:0][WB-1:0] win_t;
    typedef struct {
        win_t w;
        bit   last;
    } exp_t;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic [WB-1:0] pix_in    = '0;
    logic          pix_valid = 1'b0;
    logic          pix_last  = 1'b0;
    logic          win_ready = 1'b1;
    logic          pix_ready;
    win_t          win_out;
    logic          win_valid;
    logic          frame_done;
`ifdef CONV_WINDOW_GEN_LAST_CHECK_EN
    logic          frame_err;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_win = 0;
    int   n0;
    exp_t exp_q[$];
    exp_t e;
    bit   fd_seen = 1'b0;
    win_t first_w, last_w, f2_first_w;

    conv_window_gen #(
        .SIZE      (SIZE),
        .WIDTH_BIT (WB),
        .IMG_W     (IW),
        .IMG_H     (IH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
`ifdef CONV_WINDOW_GEN_LAST_CHECK_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic win_t mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        win_t w;
        w[0][0] = WB'(a0); w[0][1] = WB'(a1); w[0][2] = WB'(a2);
        w[1][0] = WB'(a3); w[1][1] = WB'(a4); w[1][2] = WB'(a5);
        w[2][0] = WB'(a6); w[2][1] = WB'(a7); w[2][2] = WB'(a8);
        return w;
    endfunction

    // Window whose top-left pixel sits at (r0, c0) of a frame starting at value base.
    function automatic win_t mk_win(input int base, input int r0, input int c0);
        win_t w;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                w[i][j] = WB'(base + (r0 + i) * IW + c0 + j);
        return w;
    endfunction

    // Monitor: pops one expectation per window handshake.
    always @(negedge clock) begin
        if (frame_done && !win_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_done_without_window: got frame_done=1 win_valid=0 expected win_valid=1");
        end
        if (win_valid && win_ready) begin
            n_win++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_window: got %0h expected no window", win_out);
            end else begin
                e = exp_q.pop_front();
                check("window_data", win_out, e.w);
                check("window_frame_done", 72'(fd_seen || frame_done), 72'(e.last));
            end
            fd_seen = 1'b0;
        end else if (frame_done) begin
            fd_seen = 1'b1;
        end
    end

    task automatic send_range(input int base, input int from, input int to, input int bad);
        for (int idx = from; idx <= to; idx++) begin
            int r   = idx / IW;
            int c   = idx % IW;
            int cyc = 0;
            bit ok  = 1'b0;
            exp_t x;
            pix_in    = WB'(base + idx);
            pix_valid = 1'b1;
            pix_last  = (idx == NPIX - 1) || (idx == bad);
            do begin
                @(negedge clock);
                ok = pix_ready;
                @(posedge clock);
                #1;
                cyc++;
            end while (!ok && cyc < 50);
            if (!ok) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: pixel %0d got no pix_ready expected accept within 50 cycles", idx);
            end else if (r >= SIZE - 1 && c >= SIZE - 1) begin
                x.w    = mk_win(base, r - (SIZE - 1), c - (SIZE - 1));
                x.last = (idx == NPIX - 1);
                exp_q.push_back(x);
            end
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("drain_queue_empty", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_win_valid"}, 72'(win_valid), 72'd0);
        check({tag, "_frame_done"}, 72'(frame_done), 72'd0);
        check({tag, "_win_out"}, win_out, 72'd0);
        check({tag, "_pix_ready"}, 72'(pix_ready), 72'd1);
    endtask

    initial begin
        first_w    = mk9(0, 1, 2, 5, 6, 7, 10, 11, 12);
        last_w     = mk9(7, 8, 9, 12, 13, 14, 17, 18, 19);
        f2_first_w = mk9(100, 101, 102, 105, 106, 107, 110, 111, 112);

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("por");
        reset = 1'b0;

        // Back-to-back frame: first and last windows, frame_done pulse.
        n0 = n_win;
        send_range(0, 0, 12, -1);
        check("first_win_valid", 72'(win_valid), 72'd1);
        check("first_win", win_out, first_w);
        send_range(0, 13, 19, -1);
        check("last_win_valid", 72'(win_valid), 72'd1);
        check("last_win", win_out, last_w);
        check("frame_done_on_last", 72'(frame_done), 72'd1);
        @(posedge clock);
        #1;
        check("frame_done_single_pulse", 72'(frame_done), 72'd0);
        drain();
        check("windows_frame1", 72'(n_win - n0), 72'd6);

        // Stall on the first window for 4 cycles.
        n0 = n_win;
        win_ready = 1'b0;
        send_range(0, 0, 12, -1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("stall_win_stable", win_out, first_w);
            check("stall_win_valid", 72'(win_valid), 72'd1);
            check("stall_pix_ready", 72'(pix_ready), 72'd0);
            @(posedge clock);
            #1;
        end
        win_ready = 1'b1;
        send_range(0, 13, 19, -1);
        drain();
        check("windows_stalled_frame", 72'(n_win - n0), 72'd6);

        // Two frames back-to-back, second offset by 100.
        n0 = n_win;
        send_range(0, 0, 19, -1);
        send_range(100, 0, 12, -1);
        check("frame2_first_valid", 72'(win_valid), 72'd1);
        check("frame2_first_win", win_out, f2_first_w);
        send_range(100, 13, 19, -1);
        drain();
        check("windows_two_frames", 72'(n_win - n0), 72'd12);

        // Reset after pixel 13, then a full fresh frame.
        n0 = n_win;
        send_range(0, 0, 13, -1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state("midframe_reset");
        send_range(0, 0, 11, -1);
        check("no_win_before_px12", 72'(win_valid), 72'd0);
        send_range(0, 12, 12, -1);
        check("after_reset_first_win", win_out, first_w);
        send_range(0, 13, 19, -1);
        drain();
        check("windows_reset_test", 72'(n_win - n0), 72'd8);

`ifdef CONV_WINDOW_GEN_LAST_CHECK_EN
        check("frame_err_clean", 72'(frame_err), 72'd0);
        send_range(0, 0, 9, -1);
        send_range(0, 10, 10, 10);
        check("frame_err_rises", 72'(frame_err), 72'd1);
        send_range(0, 11, 19, -1);
        drain();
        check("frame_err_sticky", 72'(frame_err), 72'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("frame_err_reset", 72'(frame_err), 72'd0);
`endif

        repeat (3) @(posedge clock);
        #1;
        check("final_queue_empty", 72'(exp_q.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_conv_window_gen
